// File: rtl/apb_pkg.sv
// Shared types and default widths for the APB master bridge.
package apb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } apb_state_e;

  localparam int APB_ADDR_W = 16;
  localparam int APB_DATA_W = 32;
  localparam int APB_STRB_W = 4;

endpackage

// File: rtl/apb_master_fsm.sv
// Command-to-APB master bridge: one transfer in flight, registered APB and
// response outputs, bounded slave wait states.
module apb_master_fsm
  import apb_pkg::*;
#(
  parameter int ADDR_W         = APB_ADDR_W,
  parameter int DATA_W         = APB_DATA_W,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                PCLOCK,
  input  logic                PRESETn,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic                cmd_write,
  input  logic [ADDR_W-1:0]   cmd_addr,
  input  logic [DATA_W-1:0]   cmd_wdata,
  input  logic [DATA_W/8-1:0] cmd_strb,
  input  logic                cmd_prot,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [DATA_W-1:0]   rsp_rdata,
  output logic                rsp_err,
  output logic                rsp_timeout,
  output logic [ADDR_W-1:0]   PADDR,
  output logic                PPROT,
  output logic                PSEL,
  output logic                PENABLE,
  output logic                PWRITE,
  output logic [DATA_W-1:0]   PWDATA,
  output logic [DATA_W/8-1:0] PSTRB,
  input  logic                PREADY,
  input  logic [DATA_W-1:0]   PRDATA,
  input  logic                PSLVERR
);

  localparam int STRB_W = DATA_W / 8;
  localparam int CNT_W  = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam bit TIMEOUT_EN = (TIMEOUT_CYCLES > 0);
  localparam logic [CNT_W-1:0] CNT_LIMIT =
    CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  apb_state_e         state_reg, state_next;
  logic [CNT_W-1:0]   cnt_reg, cnt_next;

  logic [ADDR_W-1:0]  paddr_next;
  logic               pprot_next, psel_next, penable_next, pwrite_next;
  logic [DATA_W-1:0]  pwdata_next;
  logic [STRB_W-1:0]  pstrb_next;
  logic               rsp_valid_next, rsp_err_next, rsp_timeout_next;
  logic [DATA_W-1:0]  rsp_rdata_next;

  assign cmd_ready = (state_reg == IDLE);

  always_ff @(posedge PCLOCK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_reg   <= IDLE;
      cnt_reg     <= '0;
      PADDR       <= '0;
      PPROT       <= 1'b0;
      PSEL        <= 1'b0;
      PENABLE     <= 1'b0;
      PWRITE      <= 1'b0;
      PWDATA      <= '0;
      PSTRB       <= '0;
      rsp_valid   <= 1'b0;
      rsp_err     <= 1'b0;
      rsp_timeout <= 1'b0;
      rsp_rdata   <= '0;
    end else begin
      state_reg   <= state_next;
      cnt_reg     <= cnt_next;
      PADDR       <= paddr_next;
      PPROT       <= pprot_next;
      PSEL        <= psel_next;
      PENABLE     <= penable_next;
      PWRITE      <= pwrite_next;
      PWDATA      <= pwdata_next;
      PSTRB       <= pstrb_next;
      rsp_valid   <= rsp_valid_next;
      rsp_err     <= rsp_err_next;
      rsp_timeout <= rsp_timeout_next;
      rsp_rdata   <= rsp_rdata_next;
    end
  end

  always_comb begin
    state_next       = state_reg;
    cnt_next         = cnt_reg;
    paddr_next       = PADDR;
    pprot_next       = PPROT;
    psel_next        = PSEL;
    penable_next     = PENABLE;
    pwrite_next      = PWRITE;
    pwdata_next      = PWDATA;
    pstrb_next       = PSTRB;
    rsp_valid_next   = rsp_valid;
    rsp_err_next     = rsp_err;
    rsp_timeout_next = rsp_timeout;
    rsp_rdata_next   = rsp_rdata;

    unique case (state_reg)
      IDLE: begin
        if (cmd_valid) begin
          paddr_next   = cmd_addr;
          pprot_next   = cmd_prot;
          pwrite_next  = cmd_write;
          // Reads drive zero data and strobes onto the bus.
          pwdata_next  = cmd_write ? cmd_wdata : '0;
          pstrb_next   = cmd_write ? cmd_strb  : '0;
          psel_next    = 1'b1;
          penable_next = 1'b0;
          state_next   = SETUP;
        end
      end
      SETUP: begin
        penable_next = 1'b1;
        cnt_next     = '0;
        state_next   = ACCESS;
      end
      ACCESS: begin
        if (PREADY) begin
          rsp_err_next     = PSLVERR;
          rsp_rdata_next   = PWRITE ? '0 : PRDATA;
          rsp_timeout_next = 1'b0;
          rsp_valid_next   = 1'b1;
          psel_next        = 1'b0;
          penable_next     = 1'b0;
          state_next       = RESP;
        end else if (TIMEOUT_EN && (cnt_reg == CNT_LIMIT)) begin
          rsp_err_next     = 1'b1;
          rsp_timeout_next = 1'b1;
          rsp_rdata_next   = '0;
          rsp_valid_next   = 1'b1;
          psel_next        = 1'b0;
          penable_next     = 1'b0;
          state_next       = RESP;
        end else if (cnt_reg != CNT_MAX) begin
          // Saturate so an unbounded wait never wraps the counter.
          cnt_next = cnt_reg + 1'b1;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          rsp_valid_next = 1'b0;
          state_next     = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: doc/apb_master_fsm.md
Name: apb_master_fsm

Overview:
Command-to-APB bridge that drives the APB master side of the bus from a simple valid/ready command channel. It returns a valid/ready response and sits directly upstream of the APB bus and its slaves. The block sequences the SETUP and ACCESS phases, tolerates slave wait states, and bounds them with a timeout. One transfer is in flight at a time.

Parameters:
ADDR_W, 16, PADDR / cmd_addr width
DATA_W, 32, PWDATA / PRDATA width; PSTRB width = DATA_W/8
TIMEOUT_CYCLES, 16, maximum ACCESS cycles before abort; 0 disables the timeout

Ports:
PCLOCK  in  1  bus clock; all logic on rising edge
PRESETn  in  1  asynchronous active-low reset
cmd_valid  in  1  command present
cmd_ready  out  1  command accepted when cmd_valid and cmd_ready are both high
cmd_write  in  1  1 = write, 0 = read
cmd_addr  in  ADDR_W  target address, passed through unchanged
cmd_wdata  in  DATA_W  write data
cmd_strb  in  DATA_W/8  write byte strobes
cmd_prot  in  1  protection attribute
rsp_valid  out  1  response present
rsp_ready  in  1  response consumed when rsp_valid and rsp_ready are both high
rsp_rdata  out  DATA_W  read data; 0 for writes and timeouts
rsp_err  out  1  PSLVERR seen or timeout occurred
rsp_timeout  out  1  transfer aborted by timeout
PADDR  out  ADDR_W  APB address
PPROT  out  1  APB protection
PSEL  out  1  APB select
PENABLE  out  1  APB enable
PWRITE  out  1  APB direction
PWDATA  out  DATA_W  APB write data
PSTRB  out  DATA_W/8  APB strobes
PREADY  in  1  slave ready
PRDATA  in  DATA_W  slave read data
PSLVERR  in  1  slave error

Behaviour:
- Clock and reset: one clock, PCLOCK. Reset is asynchronous, active-low, PRESETn.
- Reset values: all outputs 0 and state IDLE. cmd_ready is derived as (state==IDLE), so it reads 1 during reset.
- Registered outputs: all APB outputs and all rsp_* outputs come straight from flops; none has a combinational path from an input.
- States: IDLE, SETUP, ACCESS, RESP.
- IDLE: cmd_ready=1. On cmd_valid, latch addr/write/wdata/strb/prot into the APB output registers and go to SETUP.
  - Write: PWDATA=cmd_wdata, PSTRB=cmd_strb.
  - Read: PWDATA=0, PSTRB=0.
- SETUP (exactly 1 cycle): PSEL=1, PENABLE=0. Go to ACCESS with PENABLE=1.
- ACCESS: PSEL=1, PENABLE=1; PADDR, PWRITE, PWDATA, PSTRB, PPROT held stable.
  - Wait counter starts at 0 on entry and increments each cycle PREADY=0.
  - PREADY=1: latch PSLVERR into rsp_err; latch PRDATA into rsp_rdata on reads (0 on writes); rsp_timeout=0; PSEL=PENABLE=0; go to RESP.
  - Timeout (TIMEOUT_CYCLES>0, PREADY=0 and counter==TIMEOUT_CYCLES-1): rsp_err=1, rsp_timeout=1, rsp_rdata=0, PSEL=PENABLE=0, go to RESP.
  - ACCESS therefore lasts at most TIMEOUT_CYCLES cycles.
  - PREADY=1 on the limit cycle counts as normal completion, not a timeout.
- RESP: rsp_valid=1; rsp_* held stable until rsp_ready. On the handshake, rsp_valid=0 and go to IDLE. PADDR and the other APB outputs keep their last value.
- Latency:
  - Zero-wait transfer: cmd accept → rsp_valid = 3 cycles.
  - Minimum command spacing: 4 cycles when rsp_ready is tied high.
- Simultaneous events: cmd_valid during SETUP/ACCESS/RESP is ignored (cmd_ready=0). A pending cmd is accepted on the first IDLE cycle.
- Reset mid-transfer: PSEL/PENABLE/rsp_valid drop immediately and asynchronously; the transfer is lost and no response is issued.
- Counter width is $clog2(TIMEOUT_CYCLES+1), minimum 1; it must not wrap.

Decomposition:
- Package apb_pkg: state enum apb_state_e {IDLE,SETUP,ACCESS,RESP} and constants APB_ADDR_W=16, APB_DATA_W=32, APB_STRB_W=4.
- Single module; no sub-module is needed. The timeout counter is inline.

Test Plan:
- Write, zero wait: addr=0x0010, wdata=0xDEADBEEF, strb=0xF → PSEL rises 1 cycle after accept, PENABLE next cycle, PREADY=1 → rsp_valid 3 cycles after accept, rsp_err=0, rsp_rdata=0.
- Read, 3 wait states: addr=0x0024, PRDATA=0x12345678 on the 4th ACCESS cycle → PSTRB=0, rsp_rdata=0x12345678, rsp_valid 6 cycles after accept.
- Slave error: read with PSLVERR=1 alongside PREADY → rsp_err=1, rsp_timeout=0.
- Timeout: TIMEOUT_CYCLES=4, PREADY held 0 → PSEL/PENABLE drop after 4 ACCESS cycles; rsp_err=1, rsp_timeout=1, rsp_rdata=0. Repeat with PREADY=1 on the 4th cycle → normal completion.
- Backpressure and back-to-back: cmd_valid held high for 2 commands, rsp_ready low for 5 cycles → rsp_* stable, cmd_ready=0 throughout RESP, second SETUP only after the response handshake.
- Reset mid-ACCESS: assert PRESETn=0 during a wait state → PSEL=PENABLE=rsp_valid=0 with no clock edge; after release a new write completes normally.
